// File: rtl/clk_edge_monitor_pkg.sv
// ============================================================================
// Module      : clk_edge_monitor_pkg
// Description : Shared state encoding and default parameter values for the
//               clk_edge_monitor receive-side edge/period monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_edge_monitor_pkg;

  // Monitor state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  // Default parameter values
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_TOL        = 1;
  localparam int DEF_TIMEOUT    = 1024;

endpackage

`default_nettype wire

// File: rtl/sync_rise_det.sv
// ============================================================================
// Module      : sync_rise_det
// Description : Two-flop synchronizer for an asynchronous level, followed by
//               a history flop.  rise_o is high for the one cycle in which
//               the synchronized level has just gone from 0 to 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Metastability chain plus one cycle of history for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/clk_edge_monitor.sv
// ============================================================================
// Module      : clk_edge_monitor
// Description : Samples a divided clock-like input in the CLK domain, emits a
//               one-cycle TICK per rising edge, measures the input period in
//               CLK cycles and tracks lock / loss of the signal.
//               Optional macro CLK_EDGE_MONITOR_DUTY_EN adds HIGH_CNT, the
//               high time of the last complete period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_edge_monitor
  import clk_edge_monitor_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TOL        = DEF_TOL,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN,
  output logic             TICK,
  output logic [CNT_W-1:0] PERIOD,
  output logic             LOCKED,
  output logic             LOST
`ifdef CLK_EDGE_MONITOR_DUTY_EN
  ,
  output logic [CNT_W-1:0] HIGH_CNT
`endif
);

  localparam int                 MATCH_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   TOL_C        = CNT_W'(TOL);
  localparam logic [MATCH_W-1:0] LOCK_TARGET  = MATCH_W'(LOCK_COUNT);

  // Counters stick at all-ones so an absent input never wraps into a
  // plausible-looking period.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic rise;
  logic sync_level;

  sync_rise_det u_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .din_i   (DIN),
    .level_o (sync_level),
    .rise_o  (rise)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ref_q, ref_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               tick_q;
  logic               locked_q;
  logic               lost_q;

  logic [CNT_W-1:0]   meas;
  logic [CNT_W-1:0]   diff;
  logic               out_tol;
  logic               timeout;
  logic [MATCH_W-1:0] match_inc;

  // Measurement and tolerance compare for the rise being handled this cycle
  always_comb begin
    meas      = sat_inc(cnt_q);
    diff      = (meas >= ref_q) ? (meas - ref_q) : (ref_q - meas);
    out_tol   = (diff > TOL_C);
    timeout   = (cnt_q == TIMEOUT_LAST);
    match_inc = match_q + 1'b1;
  end

  // Next-state logic: a rise always takes priority over a timeout
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    period_d = period_q;
    cnt_d    = rise ? '0 : sat_inc(cnt_q);
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_ACQUIRE;
          ref_d   = '0;
          match_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (rise) begin
          period_d = meas;
          if ((ref_q == '0) || out_tol) begin
            ref_d   = meas;
            match_d = '0;
          end else begin
            match_d = match_inc;
            if (match_inc == LOCK_TARGET) begin
              state_d = ST_LOCKED;
            end
          end
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          period_d = meas;
          if (out_tol) begin
            state_d = ST_ACQUIRE;
            ref_d   = meas;
            match_d = '0;
          end
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        // First rise after loss only restarts the counter; PERIOD is kept
        if (rise) begin
          state_d = ST_ACQUIRE;
          ref_d   = '0;
          match_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs; LOCKED/LOST decode the next state so
  // they change on the same edge as the state itself
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      ref_q    <= '0;
      match_q  <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      period_q <= period_d;
      tick_q   <= rise;
      locked_q <= (state_d == ST_LOCKED);
      lost_q   <= (state_d == ST_LOST);
    end
  end

  assign TICK   = tick_q;
  assign PERIOD = period_q;
  assign LOCKED = locked_q;
  assign LOST   = lost_q;

`ifdef CLK_EDGE_MONITOR_DUTY_EN
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;

  // High-time accumulation; the rise cycle itself is the first high cycle
  // of the new period, so the counter restarts at 1
  always_comb begin
    high_cnt_d = high_cnt_q;
    if (rise) begin
      high_d = CNT_W'(1);
    end else if (sync_level) begin
      high_d = sat_inc(high_q);
    end else begin
      high_d = high_q;
    end
    if (rise && ((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED))) begin
      high_cnt_d = high_q;
    end
  end

  // High-time registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      high_q     <= '0;
      high_cnt_q <= '0;
    end else begin
      high_q     <= high_d;
      high_cnt_q <= high_cnt_d;
    end
  end

  assign HIGH_CNT = high_cnt_q;
`else
  // Synchronized level is only consumed by the high-time counter
  logic sync_level_unused;
  assign sync_level_unused = sync_level;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_edge_monitor.sv
// ============================================================================
// Module      : tb_clk_edge_monitor
// Description : Directed self-checking bench for clk_edge_monitor.
//               Exercises HIGH_CNT when CLK_EDGE_MONITOR_DUTY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_edge_monitor;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             DIN;
  logic             TICK;
  logic [CNT_W-1:0] PERIOD;
  logic             LOCKED;
  logic             LOST;
`ifdef CLK_EDGE_MONITOR_DUTY_EN
  logic [CNT_W-1:0] HIGH_CNT;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int tick_seen   = 0;

  clk_edge_monitor #(
    .CNT_W      (CNT_W),
    .LOCK_COUNT (4),
    .TOL        (1),
    .TIMEOUT    (1024)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .DIN    (DIN),
    .TICK   (TICK),
    .PERIOD (PERIOD),
    .LOCKED (LOCKED),
    .LOST   (LOST)
`ifdef CLK_EDGE_MONITOR_DUTY_EN
    ,
    .HIGH_CNT (HIGH_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Count TICK pulses, sampled away from the active edge
  always @(negedge CLK) begin
    if (TICK === 1'b1) tick_seen++;
  end

  // Advance n rising edges, then settle 1 time unit
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic din_period(input int hi, input int lo);
    DIN = 1'b1;
    step(hi);
    DIN = 1'b0;
    step(lo);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    DIN = 1'b0;
    step(2);
    RST = 1'b0;
  endtask

  // Reset followed by six 4-cycle periods: lock on the sixth rise
  task automatic lock_50mhz();
    apply_reset();
    repeat (6) din_period(2, 2);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DIN = 1'b1;
    step(3);
    vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %0b want 0", TICK); end
    vectors++; if (PERIOD !== '0) begin miscompares++; $display("FAIL reset_period: got %0d want 0", PERIOD); end
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0b want 0", LOCKED); end
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL reset_lost: got %0b want 0", LOST); end
`ifdef CLK_EDGE_MONITOR_DUTY_EN
    vectors++; if (HIGH_CNT !== '0) begin miscompares++; $display("FAIL reset_high_cnt: got %0d want 0", HIGH_CNT); end
`endif
    DIN = 1'b0;
    RST = 1'b0;
    step(3);
    vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL idle_tick: got %0b want 0", TICK); end
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL idle_lost: got %0b want 0", LOST); end
  endtask

  task automatic test_50mhz();
    int t0;
    apply_reset();
    t0 = tick_seen;
    DIN = 1'b1;
    step(2);
    vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL latency_early: got %0b want 0", TICK); end
    DIN = 1'b0;
    step(1);
    vectors++; if (TICK !== 1'b1) begin miscompares++; $display("FAIL latency_third_edge: got %0b want 1", TICK); end
    vectors++; if (PERIOD !== 16'd0) begin miscompares++; $display("FAIL first_rise_period: got %0d want 0", PERIOD); end
    step(1);
    vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL tick_width: got %0b want 0", TICK); end
    repeat (4) din_period(2, 2);
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL lock_after5: got %0b want 0", LOCKED); end
    vectors++; if (PERIOD !== 16'd4) begin miscompares++; $display("FAIL period_50mhz: got %0d want 4", PERIOD); end
    din_period(2, 2);
    vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL lock_after6: got %0b want 1", LOCKED); end
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL lost_50mhz: got %0b want 0", LOST); end
    vectors++; if ((tick_seen - t0) !== 6) begin miscompares++; $display("FAIL tick_count: got %0d want 6", tick_seen - t0); end
  endtask

  task automatic test_jitter();
    apply_reset();
    din_period(2, 2);   // 4: start
    din_period(3, 2);   // 5
    din_period(2, 2);   // 4
    din_period(2, 1);   // 3
    din_period(2, 2);   // 4
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL jitter_prelock: got %0b want 0", LOCKED); end
    vectors++; if (PERIOD !== 16'd3) begin miscompares++; $display("FAIL jitter_period3: got %0d want 3", PERIOD); end
    din_period(3, 4);   // 7, its starting rise is the fourth match
    vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL jitter_lock: got %0b want 1", LOCKED); end
    vectors++; if (PERIOD !== 16'd4) begin miscompares++; $display("FAIL jitter_period4: got %0d want 4", PERIOD); end
    DIN = 1'b1;
    step(3);
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL jitter_unlock: got %0b want 0", LOCKED); end
    vectors++; if (PERIOD !== 16'd7) begin miscompares++; $display("FAIL jitter_period7: got %0d want 7", PERIOD); end
    DIN = 1'b0;
    step(4);
    repeat (3) din_period(3, 4);
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL relock_early: got %0b want 0", LOCKED); end
    DIN = 1'b1;
    step(3);
    vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL relock_ref7: got %0b want 1", LOCKED); end
    DIN = 1'b0;
    step(4);
  endtask

  task automatic test_timeout();
    lock_50mhz();
    step(1022);
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL timeout_early_lost: got %0b want 0", LOST); end
    vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL timeout_early_locked: got %0b want 1", LOCKED); end
    step(1);
    vectors++; if (LOST !== 1'b1) begin miscompares++; $display("FAIL timeout_lost: got %0b want 1", LOST); end
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL timeout_locked: got %0b want 0", LOCKED); end
    DIN = 1'b1;
    step(2);
    DIN = 1'b0;
    step(1);
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL restart_lost: got %0b want 0", LOST); end
    vectors++; if (PERIOD !== 16'd4) begin miscompares++; $display("FAIL restart_period_kept: got %0d want 4", PERIOD); end
    step(3);
    DIN = 1'b1;
    step(2);
    DIN = 1'b0;
    step(1);
    vectors++; if (PERIOD !== 16'd6) begin miscompares++; $display("FAIL restart_period6: got %0d want 6", PERIOD); end
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL restart_locked: got %0b want 0", LOCKED); end
    step(3);
  endtask

  task automatic test_reset_mid_lock();
    lock_50mhz();
    DIN = 1'b1;
    step(2);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    DIN = 1'b0;
    vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL midrst_tick: got %0b want 0", TICK); end
    vectors++; if (PERIOD !== '0) begin miscompares++; $display("FAIL midrst_period: got %0d want 0", PERIOD); end
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL midrst_locked: got %0b want 0", LOCKED); end
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL midrst_lost: got %0b want 0", LOST); end
    step(2);
    repeat (5) din_period(2, 2);
    vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL midrst_relock_early: got %0b want 0", LOCKED); end
    din_period(2, 2);
    vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL midrst_relock: got %0b want 1", LOCKED); end
    vectors++; if (PERIOD !== 16'd4) begin miscompares++; $display("FAIL midrst_period4: got %0d want 4", PERIOD); end
  endtask

  task automatic test_tie();
    apply_reset();
    din_period(2, 1022);   // first rise, then 1024 cycles to the next
    DIN = 1'b1;
    step(2);
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL tie_pre_lost: got %0b want 0", LOST); end
    DIN = 1'b0;
    step(1);
    vectors++; if (LOST !== 1'b0) begin miscompares++; $display("FAIL tie_lost: got %0b want 0", LOST); end
    vectors++; if (PERIOD !== 16'd1024) begin miscompares++; $display("FAIL tie_period: got %0d want 1024", PERIOD); end
    vectors++; if (TICK !== 1'b1) begin miscompares++; $display("FAIL tie_tick: got %0b want 1", TICK); end
    step(2);
  endtask

`ifdef CLK_EDGE_MONITOR_DUTY_EN
  task automatic test_duty();
    apply_reset();
    din_period(3, 5);
    DIN = 1'b1;
    step(3);
    vectors++; if (PERIOD !== 16'd8) begin miscompares++; $display("FAIL duty_period: got %0d want 8", PERIOD); end
    vectors++; if (HIGH_CNT !== 16'd3) begin miscompares++; $display("FAIL duty_high3: got %0d want 3", HIGH_CNT); end
    DIN = 1'b0;
    step(5);
    din_period(5, 3);
    DIN = 1'b1;
    step(3);
    vectors++; if (PERIOD !== 16'd8) begin miscompares++; $display("FAIL duty_period2: got %0d want 8", PERIOD); end
    vectors++; if (HIGH_CNT !== 16'd5) begin miscompares++; $display("FAIL duty_high5: got %0d want 5", HIGH_CNT); end
    DIN = 1'b0;
    step(2);
  endtask
`endif

  initial begin
    RST = 1'b1;
    DIN = 1'b0;
    test_reset();
    test_50mhz();
    test_jitter();
    test_timeout();
    test_reset_mid_lock();
    test_tie();
`ifdef CLK_EDGE_MONITOR_DUTY_EN
    test_duty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
